// File: rtl/vec_mem_pkg.sv
// Shared types and sizing for the vector memory address-generation unit.
package vec_mem_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 64;
    localparam int unsigned DW_B       = DATA_WIDTH >> 3;
    localparam int unsigned LEN_BITS   = 9;
    localparam int unsigned BEAT_BYTES = 8;
    localparam int unsigned ALIGN_BITS = $clog2(BEAT_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_XFER,
        ST_WAIT
    } agu_state_t;

    typedef struct packed {
        logic                  store;
        logic [ADDR_WIDTH-1:0] base;
        logic [ADDR_WIDTH-1:0] stride;
        logic [LEN_BITS-1:0]   beats;
    } agu_cmd_t;

    function automatic logic is_aligned(input logic [ADDR_WIDTH-1:0] a);
        return a[ALIGN_BITS-1:0] == ALIGN_BITS'(0);
    endfunction

endpackage

// File: rtl/vec_mem_agu_if.sv
// Command, store-data, mem_queue and writeback signals of the vector AGU.
interface vec_mem_agu_if;
    import vec_mem_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_store;
    logic [ADDR_WIDTH-1:0] cmd_base;
    logic [ADDR_WIDTH-1:0] cmd_stride;
    logic [LEN_BITS-1:0]   cmd_beats;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_data_valid;
    logic                  st_data_ready;
    logic [ADDR_WIDTH-1:0] mq_addr;
    logic                  mq_req;
    logic                  mq_valid;
    logic                  mq_start;
    logic [DATA_WIDTH-1:0] mq_data;
    logic [DW_B-1:0]       mq_be;
    logic                  mq_ready;
    logic [DATA_WIDTH-1:0] mq_ld_data;
    logic                  mq_ld_valid;
    logic                  mq_done_ld;
    logic                  mq_done_st;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_valid;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output cmd_valid, cmd_store, cmd_base, cmd_stride, cmd_beats,
               st_data, st_data_valid, mq_ld_data, mq_ld_valid, mq_done_ld, mq_done_st,
        input  cmd_ready, st_data_ready, mq_addr, mq_req, mq_valid, mq_start, mq_data,
               mq_be, mq_ready, ld_data, ld_valid, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_store, cmd_base, cmd_stride, cmd_beats,
               st_data, st_data_valid, mq_ld_data, mq_ld_valid, mq_done_ld, mq_done_st,
        output cmd_ready, st_data_ready, mq_addr, mq_req, mq_valid, mq_start, mq_data,
               mq_be, mq_ready, ld_data, ld_valid, busy, done, err
    );

endinterface

// File: rtl/vec_mem_agu.sv
// Expands one strided vector load/store command into the per-beat mem_queue
// request stream, forwards load beats to writeback and reports completion.
module vec_mem_agu
    import vec_mem_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    vec_mem_agu_if.slave bus
);

    agu_state_t            state_q, state_d;
    agu_cmd_t              cmd_in;
    logic                  store_q, store_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [LEN_BITS-1:0]   beats_q, beats_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [LEN_BITS-1:0]   cnt_q, cnt_d;
    logic [LEN_BITS-1:0]   rcv_q, rcv_d;
    logic [ADDR_WIDTH-1:0] mq_addr_q, mq_addr_d;
    logic                  mq_req_q, mq_req_d;
    logic                  mq_valid_q, mq_valid_d;
    logic                  mq_start_q, mq_start_d;
    logic [DATA_WIDTH-1:0] mq_data_q, mq_data_d;
    logic [DW_B-1:0]       mq_be_q, mq_be_d;
    logic                  mq_ready_q, mq_ready_d;
    logic [DATA_WIDTH-1:0] ld_data_q, ld_data_d;
    logic                  ld_valid_q, ld_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;

    assign cmd_in = '{store: bus.cmd_store, base: bus.cmd_base,
                      stride: bus.cmd_stride, beats: bus.cmd_beats};

    // Next-state, address accumulator and beat/receive counters
    always_comb begin
        state_d     = state_q;
        store_d     = store_q;
        stride_d    = stride_q;
        beats_d     = beats_q;
        next_addr_d = next_addr_q;
        cnt_d       = cnt_q;
        rcv_d       = rcv_q;
        mq_addr_d   = mq_addr_q;
        mq_data_d   = mq_data_q;
        ld_data_d   = ld_data_q;
        mq_req_d    = 1'b0;
        mq_valid_d  = 1'b0;
        mq_start_d  = 1'b0;
        ld_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (bus.mq_ld_valid && (state_q == LD_REQ || state_q == LD_WAIT)) begin
            ld_valid_d = 1'b1;
            ld_data_d  = bus.mq_ld_data;
            rcv_d      = rcv_q + LEN_BITS'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    store_d  = cmd_in.store;
                    stride_d = cmd_in.stride;
                    beats_d  = cmd_in.beats;
                    rcv_d    = '0;
                    cnt_d    = '0;
                    if (!is_aligned(cmd_in.base) || !is_aligned(cmd_in.stride)) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (cmd_in.beats == '0) begin
                        done_d = 1'b1;
                    end else if (cmd_in.store) begin
                        state_d     = ST_XFER;
                        next_addr_d = cmd_in.base;
                    end else begin
                        // First load request leaves with the handshake cycle
                        state_d     = LD_REQ;
                        mq_req_d    = 1'b1;
                        mq_addr_d   = cmd_in.base;
                        next_addr_d = cmd_in.base + cmd_in.stride;
                        cnt_d       = LEN_BITS'(1);
                    end
                end
            end
            LD_REQ: begin
                if (cnt_q == beats_q) begin
                    state_d = LD_WAIT;
                end else begin
                    mq_req_d    = 1'b1;
                    mq_addr_d   = next_addr_q;
                    next_addr_d = next_addr_q + stride_q;
                    cnt_d       = cnt_q + LEN_BITS'(1);
                end
            end
            LD_WAIT: begin
                if (bus.mq_done_ld) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = (rcv_d != beats_q);
                end
            end
            ST_XFER: begin
                if (bus.st_data_valid) begin
                    mq_valid_d  = 1'b1;
                    mq_data_d   = bus.st_data;
                    mq_start_d  = (cnt_q == '0);
                    mq_addr_d   = next_addr_q;
                    next_addr_d = next_addr_q + stride_q;
                    cnt_d       = cnt_q + LEN_BITS'(1);
                    if (cnt_d == beats_q) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (bus.mq_done_st) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        mq_ready_d  = (state_d == LD_WAIT);
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE);
        mq_be_d     = '1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            stride_q    <= '0;
            beats_q     <= '0;
            next_addr_q <= '0;
            cnt_q       <= '0;
            rcv_q       <= '0;
            mq_addr_q   <= '0;
            mq_req_q    <= 1'b0;
            mq_valid_q  <= 1'b0;
            mq_start_q  <= 1'b0;
            mq_data_q   <= '0;
            mq_be_q     <= '0;
            mq_ready_q  <= 1'b0;
            ld_data_q   <= '0;
            ld_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            stride_q    <= stride_d;
            beats_q     <= beats_d;
            next_addr_q <= next_addr_d;
            cnt_q       <= cnt_d;
            rcv_q       <= rcv_d;
            mq_addr_q   <= mq_addr_d;
            mq_req_q    <= mq_req_d;
            mq_valid_q  <= mq_valid_d;
            mq_start_q  <= mq_start_d;
            mq_data_q   <= mq_data_d;
            mq_be_q     <= mq_be_d;
            mq_ready_q  <= mq_ready_d;
            ld_data_q   <= ld_data_d;
            ld_valid_q  <= ld_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.st_data_ready = (state_q == ST_XFER);
    assign bus.mq_addr       = mq_addr_q;
    assign bus.mq_req        = mq_req_q;
    assign bus.mq_valid      = mq_valid_q;
    assign bus.mq_start      = mq_start_q;
    assign bus.mq_data       = mq_data_q;
    assign bus.mq_be         = mq_be_q;
    assign bus.mq_ready      = mq_ready_q;
    assign bus.ld_data       = ld_data_q;
    assign bus.ld_valid      = ld_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err           = err_q;

    logic unused_store;
    assign unused_store = store_q;

endmodule

// File: tb/tb_vec_mem_agu.sv
// Bench for vec_mem_agu: command table plus hand sequences, with a beat
// scoreboard fed by the stimulus and drained by an output monitor.
module tb_vec_mem_agu;
    import vec_mem_pkg::*;

    logic clk;
    logic rst_n;

    vec_mem_agu_if bus_if();

    vec_mem_agu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic        start;
        logic        store;
    } beat_t;

    typedef struct {
        logic        store;
        logic [31:0] base;
        logic [31:0] stride;
        int          beats;
        int          nrecv;
        logic        exp_err;
        int          exp_nreq;
    } vec_t;

    beat_t       exp_q[$];
    logic [63:0] ld_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          req_count = 0;
    vec_t        vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: every issued beat and writeback beat is checked in order
    always @(negedge clk) begin
        beat_t e;
        if (bus_if.mq_req || bus_if.mq_valid) begin
            req_count++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got addr %0h expected none at %0t", bus_if.mq_addr, $time);
            end else begin
                e = exp_q.pop_front();
                chk("beat_addr", 64'(bus_if.mq_addr), 64'(e.addr));
                chk("beat_kind", 64'({bus_if.mq_req, bus_if.mq_valid}), e.store ? 64'd1 : 64'd2);
                chk("beat_be", 64'(bus_if.mq_be), 64'hFF);
                if (e.store) begin
                    chk("beat_data", bus_if.mq_data, e.data);
                    chk("beat_start", 64'(bus_if.mq_start), 64'(e.start));
                end
            end
        end
        if (bus_if.ld_valid) begin
            if (ld_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ld: got %0h expected none at %0t", bus_if.ld_data, $time);
            end else begin
                chk("ld_data", bus_if.ld_data, ld_q.pop_front());
            end
        end
    end

    task automatic chk_idle_outputs(input string name);
        chk(name, 64'({bus_if.cmd_ready, bus_if.busy, bus_if.done, bus_if.err, bus_if.mq_req,
                       bus_if.mq_valid, bus_if.mq_start, bus_if.mq_ready, bus_if.ld_valid,
                       bus_if.st_data_ready}), 64'h200);
        chk({name, "_addr"}, 64'(bus_if.mq_addr), 64'd0);
        chk({name, "_be"}, 64'(bus_if.mq_be), 64'd0);
        chk({name, "_mqdata"}, bus_if.mq_data, 64'd0);
        chk({name, "_lddata"}, bus_if.ld_data, 64'd0);
    endtask

    task automatic issue(input logic st, input logic [31:0] base, input logic [31:0] stride,
                         input int beats, input int nload);
        @(negedge clk);
        bus_if.cmd_store  = st;
        bus_if.cmd_base   = base;
        bus_if.cmd_stride = stride;
        bus_if.cmd_beats  = 9'(beats);
        bus_if.cmd_valid  = 1'b1;
        chk("cmd_ready", 64'(bus_if.cmd_ready), 64'd1);
        for (int i = 0; i < nload; i++)
            exp_q.push_back('{addr: base + 32'(i) * stride, data: 64'd0, start: 1'b0, store: 1'b0});
        @(posedge clk);
        #1 bus_if.cmd_valid = 1'b0;
    endtask

    task automatic load_body(input int beats, input int nrecv);
        logic [63:0] d;
        for (int i = 0; i < beats; i++) begin
            @(negedge clk);
            chk("req_contig", 64'(bus_if.mq_req), 64'd1);
        end
        @(negedge clk);
        chk("req_end", 64'(bus_if.mq_req), 64'd0);
        chk("mq_ready", 64'(bus_if.mq_ready), 64'd1);
        chk("busy_not_ready", 64'(bus_if.cmd_ready), 64'd0);
        for (int k = 0; k < nrecv; k++) begin
            d = {$urandom(), $urandom()};
            bus_if.mq_ld_data  = d;
            bus_if.mq_ld_valid = 1'b1;
            ld_q.push_back(d);
            @(negedge clk);
        end
        bus_if.mq_ld_valid = 1'b0;
        chk("no_early_done_ld", 64'(bus_if.done), 64'd0);
        bus_if.mq_done_ld = 1'b1;
        @(negedge clk);
        bus_if.mq_done_ld = 1'b0;
    endtask

    task automatic store_body(input logic [31:0] base, input logic [31:0] stride, input int beats);
        int          acc = 0;
        int          n   = 0;
        logic        tog = 1'b0;
        logic [63:0] d;
        while (acc < beats && n < 200) begin
            @(negedge clk);
            n++;
            tog = ~tog;
            chk("st_ready", 64'(bus_if.st_data_ready), 64'd1);
            bus_if.st_data_valid = tog;
            if (tog) begin
                d = {$urandom(), $urandom()};
                bus_if.st_data = d;
                exp_q.push_back('{addr: base + 32'(acc) * stride, data: d,
                                  start: (acc == 0), store: 1'b1});
                acc++;
            end
        end
        @(negedge clk);
        bus_if.st_data_valid = 1'b0;
        chk("st_ready_off", 64'(bus_if.st_data_ready), 64'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("st_drained", 64'(exp_q.size()), 64'd0);
        chk("st_wait_busy", 64'(bus_if.busy), 64'd1);
        chk("no_early_done_st", 64'(bus_if.done), 64'd0);
        bus_if.mq_done_st = 1'b1;
        @(negedge clk);
        bus_if.mq_done_st = 1'b0;
    endtask

    task automatic wait_done(input logic exp_err);
        int n = 0;
        while (!bus_if.done && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(bus_if.done), 64'd1);
        chk("done_err", 64'(bus_if.err), 64'(exp_err));
        chk("done_ready", 64'(bus_if.cmd_ready), 64'd1);
        @(negedge clk);
        chk("done_pulse", 64'(bus_if.done), 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int r0 = req_count;
        issue(v.store, v.base, v.stride, v.beats, v.store ? 0 : v.exp_nreq);
        if (v.exp_nreq == 0) begin
            @(negedge clk);
            chk("imm_done", 64'(bus_if.done), 64'd1);
            chk("imm_err", 64'(bus_if.err), 64'(v.exp_err));
            chk("imm_ready", 64'(bus_if.cmd_ready), 64'd1);
            @(negedge clk);
            chk("imm_pulse", 64'(bus_if.done), 64'd0);
        end else if (v.store) begin
            store_body(v.base, v.stride, v.beats);
            wait_done(v.exp_err);
        end else begin
            load_body(v.beats, v.nrecv);
            wait_done(v.exp_err);
        end
        chk("nreq", 64'(req_count - r0), 64'(v.exp_nreq));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        vecs[0] = '{store: 1'b0, base: 32'h0000_1000, stride: 32'd8,          beats: 4, nrecv: 4, exp_err: 1'b0, exp_nreq: 4};
        vecs[1] = '{store: 1'b1, base: 32'h0000_2000, stride: 32'hFFFF_FFF0, beats: 3, nrecv: 0, exp_err: 1'b0, exp_nreq: 3};
        vecs[2] = '{store: 1'b0, base: 32'h0000_1004, stride: 32'd8,          beats: 4, nrecv: 0, exp_err: 1'b1, exp_nreq: 0};
        vecs[3] = '{store: 1'b0, base: 32'h0000_1000, stride: 32'd8,          beats: 0, nrecv: 0, exp_err: 1'b0, exp_nreq: 0};
        vecs[4] = '{store: 1'b0, base: 32'hFFFF_FFF8, stride: 32'd8,          beats: 2, nrecv: 2, exp_err: 1'b0, exp_nreq: 2};
        vecs[5] = '{store: 1'b1, base: 32'h0000_3000, stride: 32'd12,         beats: 2, nrecv: 0, exp_err: 1'b1, exp_nreq: 0};
        vecs[6] = '{store: 1'b0, base: 32'h0000_4000, stride: 32'h40,         beats: 1, nrecv: 1, exp_err: 1'b0, exp_nreq: 1};
        vecs[7] = '{store: 1'b1, base: 32'hFFFF_FFF0, stride: 32'd8,          beats: 3, nrecv: 0, exp_err: 1'b0, exp_nreq: 3};
        vecs[8] = '{store: 1'b0, base: 32'h0000_5000, stride: 32'd8,          beats: 3, nrecv: 2, exp_err: 1'b1, exp_nreq: 3};
        vecs[9] = '{store: 1'b0, base: 32'h0000_5008, stride: 32'hFFFF_FFF8, beats: 3, nrecv: 4, exp_err: 1'b1, exp_nreq: 3};

        rst_n                = 1'b0;
        bus_if.cmd_valid     = 1'b0;
        bus_if.cmd_store     = 1'b0;
        bus_if.cmd_base      = '0;
        bus_if.cmd_stride    = '0;
        bus_if.cmd_beats     = '0;
        bus_if.st_data       = '0;
        bus_if.st_data_valid = 1'b0;
        bus_if.mq_ld_data    = '0;
        bus_if.mq_ld_valid   = 1'b0;
        bus_if.mq_done_ld    = 1'b0;
        bus_if.mq_done_st    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_vec(vecs[i]);

        // A second command held on cmd_valid waits until the first one completes
        r0 = req_count;
        issue(1'b0, 32'h0000_6000, 32'd8, 2, 2);
        bus_if.cmd_store  = 1'b0;
        bus_if.cmd_base   = 32'h0000_7000;
        bus_if.cmd_stride = 32'd8;
        bus_if.cmd_beats  = 9'd1;
        bus_if.cmd_valid  = 1'b1;
        load_body(2, 2);
        chk("bp_done", 64'(bus_if.done), 64'd1);
        chk("bp_err", 64'(bus_if.err), 64'd0);
        chk("bp_ready", 64'(bus_if.cmd_ready), 64'd1);
        exp_q.push_back('{addr: 32'h0000_7000, data: 64'd0, start: 1'b0, store: 1'b0});
        @(posedge clk);
        #1 bus_if.cmd_valid = 1'b0;
        load_body(1, 1);
        wait_done(1'b0);
        chk("bp_nreq", 64'(req_count - r0), 64'd3);

        // Reset after two of five load requests abandons the command
        r0 = req_count;
        issue(1'b0, 32'h0000_8000, 32'd8, 5, 5);
        @(negedge clk);
        chk("midrst_req1", 64'(bus_if.mq_req), 64'd1);
        @(negedge clk);
        chk("midrst_req2", 64'(bus_if.mq_req), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midrst");
        exp_q.delete();
        chk("midrst_nreq", 64'(req_count - r0), 64'd2);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 64'({bus_if.done, bus_if.mq_req}), 64'd0);
        end
        run_vec(vecs[0]);

        repeat (2) @(negedge clk);
        chk("final_ld_q_empty", 64'(ld_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
